// File: rtl/eth_mac_tx_framer.sv
// Transmit MAC framer: byte-wide AXI-Stream in, GMII out with preamble, SFD, zero pad, CRC-32 FCS and IFG.
// Every GMII output and stat pulse is registered from the next-state logic.
module eth_mac_tx_framer #(
   parameter int MIN_FRAME_BYTES = 60,
   parameter int PREAMBLE_BYTES  = 7,
   parameter int IFG_BYTES       = 12
) (
   input  logic       clk_125mhz,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       tx_busy,
   output logic       stat_frame_done,
   output logic       stat_underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_IFG,
      S_DROP
   } state_t;

   localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_BYTES);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

   // Reflected CRC-32, one byte per call, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
      logic [31:0] c;
      c = crc_in ^ {24'h00_0000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [31:0] r_crc;
   logic [31:0] w_crc_nxt;
   logic [7:0]  r_txd;
   logic [7:0]  w_txd_nxt;
   logic        r_tx_en;
   logic        w_tx_en_nxt;
   logic        r_tx_er;
   logic        w_tx_er_nxt;
   logic        r_frame_done;
   logic        w_frame_done_nxt;
   logic        r_underrun;
   logic        w_underrun_nxt;

   logic [16:0] w_cnt_plus1;
   logic [15:0] w_cnt_sat;
   logic [31:0] w_crc_data;
   logic [31:0] w_crc_pad;

   assign w_cnt_plus1 = {1'b0, r_cnt} + 17'd1;
   assign w_cnt_sat   = (r_cnt == 16'hFFFF) ? r_cnt : w_cnt_plus1[15:0];
   assign w_crc_data  = crc32_byte(r_crc, s_axis_tdata);
   assign w_crc_pad   = crc32_byte(r_crc, 8'h00);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_crc_nxt        = r_crc;
      w_txd_nxt        = 8'h00;
      w_tx_en_nxt      = 1'b0;
      w_tx_er_nxt      = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_underrun_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (s_axis_tvalid) begin
               w_state_nxt = S_PREAMBLE;
               w_txd_nxt   = 8'h55;
               w_tx_en_nxt = 1'b1;
               w_cnt_nxt   = 16'd1;
            end
         end
         S_PREAMBLE: begin
            w_txd_nxt   = 8'h55;
            w_tx_en_nxt = 1'b1;
            w_cnt_nxt   = w_cnt_plus1[15:0];
            if (r_cnt >= PRE_LAST) w_state_nxt = S_SFD;
         end
         S_SFD: begin
            w_txd_nxt   = 8'hD5;
            w_tx_en_nxt = 1'b1;
            w_crc_nxt   = CRC_INIT;
            w_cnt_nxt   = 16'd0;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (s_axis_tvalid) begin
               w_txd_nxt   = s_axis_tdata;
               w_tx_en_nxt = 1'b1;
               w_tx_er_nxt = s_axis_tuser;
               w_crc_nxt   = w_crc_data;
               w_cnt_nxt   = w_cnt_sat;
               if (s_axis_tlast) begin
                  if (w_cnt_plus1 < MIN_LEN) begin
                     w_state_nxt = S_PAD;
                  end else begin
                     w_state_nxt = S_FCS;
                     w_cnt_nxt   = 16'd0;
                  end
               end
            end else begin
               // Source starved mid-frame: poison the frame on the wire and flush the rest.
               w_tx_en_nxt    = 1'b1;
               w_tx_er_nxt    = 1'b1;
               w_underrun_nxt = 1'b1;
               w_state_nxt    = S_DROP;
            end
         end
         S_PAD: begin
            w_tx_en_nxt = 1'b1;
            w_crc_nxt   = w_crc_pad;
            w_cnt_nxt   = w_cnt_plus1[15:0];
            if (w_cnt_plus1 >= MIN_LEN) begin
               w_state_nxt = S_FCS;
               w_cnt_nxt   = 16'd0;
            end
         end
         S_FCS: begin
            w_txd_nxt   = ~r_crc[7:0];
            w_tx_en_nxt = 1'b1;
            w_crc_nxt   = {8'hFF, r_crc[31:8]};
            w_cnt_nxt   = w_cnt_plus1[15:0];
            if (r_cnt[1:0] == 2'd3) begin
               w_frame_done_nxt = 1'b1;
               w_state_nxt      = S_IFG;
               w_cnt_nxt        = 16'd0;
            end
         end
         S_IFG: begin
            w_cnt_nxt = w_cnt_plus1[15:0];
            if (r_cnt >= IFG_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 16'd0;
            end
         end
         S_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               w_state_nxt = S_IFG;
               w_cnt_nxt   = 16'd0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_125mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 16'd0;
         r_crc        <= CRC_INIT;
         r_txd        <= 8'h00;
         r_tx_en      <= 1'b0;
         r_tx_er      <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_crc        <= w_crc_nxt;
         r_txd        <= w_txd_nxt;
         r_tx_en      <= w_tx_en_nxt;
         r_tx_er      <= w_tx_er_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_underrun   <= w_underrun_nxt;
      end
   end

   // Ready is decoded from the state register only, keeping tvalid out of its path.
   assign s_axis_tready   = (r_state == S_DATA) || (r_state == S_DROP);
   assign tx_busy         = (r_state != S_IDLE);
   assign gmii_txd        = r_txd;
   assign gmii_tx_en      = r_tx_en;
   assign gmii_tx_er      = r_tx_er;
   assign stat_frame_done = r_frame_done;
   assign stat_underrun   = r_underrun;

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Randomized bench for eth_mac_tx_framer: frames are built from the framing rules in a byte-queue model
// and compared against the captured GMII stream, plus residue, gap, pulse and reset checks.
module tb_eth_mac_tx_framer;

   localparam int MIN_FRAME = 60;
   localparam int IFG       = 12;

   logic       clk_125mhz    = 1'b0;
   logic       rst_n         = 1'b0;
   logic [7:0] s_axis_tdata  = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tlast  = 1'b0;
   logic       s_axis_tuser  = 1'b0;
   logic       s_axis_tready;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       tx_busy;
   logic       stat_frame_done;
   logic       stat_underrun;

   eth_mac_tx_framer dut (
      .clk_125mhz      (clk_125mhz),
      .rst_n           (rst_n),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tuser    (s_axis_tuser),
      .gmii_txd        (gmii_txd),
      .gmii_tx_en      (gmii_tx_en),
      .gmii_tx_er      (gmii_tx_er),
      .tx_busy         (tx_busy),
      .stat_frame_done (stat_frame_done),
      .stat_underrun   (stat_underrun)
   );

   always #4 clk_125mhz = ~clk_125mhz;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // Output capture, one sample per cycle away from the active edge.
   logic [7:0] s_txd[$];
   bit         s_en[$];
   bit         s_er[$];
   bit         s_rdy[$];
   bit         s_done[$];
   bit         s_ur[$];

   always @(negedge clk_125mhz) begin
      s_txd.push_back(gmii_txd);
      s_en.push_back(gmii_tx_en);
      s_er.push_back(gmii_tx_er);
      s_rdy.push_back(s_axis_tready);
      s_done.push_back(stat_frame_done);
      s_ur.push_back(stat_underrun);
   end

   // Reference model: expected on-wire bytes per frame.
   logic [7:0] cur[$];
   logic [7:0] exp_b[$];
   bit         exp_e[$];
   int         exp_len[$];
   bit         exp_ok[$];
   int         exp_good;
   int         exp_urun;

   function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int k = 0; k < 8; k++) begin
         fb = c[0] ^ b[k];
         c  = {1'b0, c[31:1]};
         if (fb) c = c ^ 32'hEDB8_8320;
      end
      return c;
   endfunction

   task automatic clear_all();
      s_txd.delete(); s_en.delete(); s_er.delete();
      s_rdy.delete(); s_done.delete(); s_ur.delete();
      exp_b.delete(); exp_e.delete(); exp_len.delete(); exp_ok.delete();
      exp_good = 0;
      exp_urun = 0;
   endtask

   task automatic rand_frame(input int len);
      cur.delete();
      for (int i = 0; i < len; i++) cur.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic model_frame(input int u, input int tu);
      logic [31:0] c;
      int          n;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 7; i++) begin
         exp_b.push_back(8'h55); exp_e.push_back(1'b0);
      end
      exp_b.push_back(8'hD5); exp_e.push_back(1'b0);
      n = 8;
      if (u >= 0) begin
         for (int i = 0; i < u; i++) begin
            exp_b.push_back(cur[i]); exp_e.push_back(i == tu);
         end
         exp_b.push_back(8'h00); exp_e.push_back(1'b1);
         n += u + 1;
         exp_ok.push_back(1'b0);
         exp_urun++;
      end else begin
         for (int i = 0; i < cur.size(); i++) begin
            exp_b.push_back(cur[i]); exp_e.push_back(i == tu);
            c = crc_model(c, cur[i]);
         end
         n += cur.size();
         for (int i = cur.size(); i < MIN_FRAME; i++) begin
            exp_b.push_back(8'h00); exp_e.push_back(1'b0);
            c = crc_model(c, 8'h00);
            n++;
         end
         c = ~c;
         for (int k = 0; k < 4; k++) begin
            exp_b.push_back(c[8*k +: 8]); exp_e.push_back(1'b0);
         end
         n += 4;
         exp_ok.push_back(1'b1);
         exp_good++;
      end
      exp_len.push_back(n);
   endtask

   // Drives cur[] as one AXI-Stream frame; u>=0 withholds tvalid for one cycle at beat u.
   task automatic send(input int u, input int tu, input bit hold);
      int i;
      int guard;
      bit dropped;
      i = 0; guard = 0; dropped = 1'b0;
      while (i < cur.size()) begin
         @(negedge clk_125mhz);
         if (u >= 0 && i == u && !dropped && s_axis_tready) begin
            s_axis_tvalid = 1'b0;
            dropped       = 1'b1;
         end else begin
            s_axis_tdata  = cur[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == cur.size() - 1);
            s_axis_tuser  = (i == tu);
            if (s_axis_tready) i++;
         end
         guard++;
         if (guard > 3000) begin
            check("drv_timeout", 32'(i), 32'(cur.size()));
            break;
         end
      end
      if (!hold) begin
         @(negedge clk_125mhz);
         s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      end
   endtask

   task automatic drain();
      repeat (100) @(negedge clk_125mhz);
   endtask

   int g_st[$];
   int g_ln[$];

   task automatic analyze(input string tag);
      int bi, nf, n, mb, me, done_n, ur_n, er_idle;
      logic [31:0] c;
      g_st.delete(); g_ln.delete();
      done_n = 0; ur_n = 0; er_idle = 0;
      for (int i = 0; i < s_en.size(); i++) begin
         if (s_en[i]) begin
            if (i == 0 || !s_en[i-1]) begin
               g_st.push_back(i); g_ln.push_back(0);
            end
            g_ln[g_ln.size()-1] = g_ln[g_ln.size()-1] + 1;
         end else if (s_er[i]) begin
            er_idle++;
         end
         if (s_done[i]) done_n++;
         if (s_ur[i]) ur_n++;
      end
      check({tag, ":frames"}, 32'(g_st.size()), 32'(exp_len.size()));
      nf = (g_st.size() < exp_len.size()) ? g_st.size() : exp_len.size();
      bi = 0;
      for (int f = 0; f < nf; f++) begin
         check($sformatf("%s:f%0d_len", tag, f), 32'(g_ln[f]), 32'(exp_len[f]));
         n  = (g_ln[f] < exp_len[f]) ? g_ln[f] : exp_len[f];
         mb = 0; me = 0;
         for (int j = 0; j < n; j++) begin
            if (s_txd[g_st[f]+j] !== exp_b[bi+j]) mb++;
            if (s_er[g_st[f]+j] !== exp_e[bi+j]) me++;
         end
         check($sformatf("%s:f%0d_bad_bytes", tag, f), 32'(mb), 32'(0));
         check($sformatf("%s:f%0d_bad_er", tag, f), 32'(me), 32'(0));
         if (exp_ok[f]) begin
            c = 32'hFFFF_FFFF;
            for (int j = 8; j < g_ln[f]; j++) c = crc_model(c, s_txd[g_st[f]+j]);
            check($sformatf("%s:f%0d_residue", tag, f), c, 32'hDEBB_20E3);
         end
         bi += exp_len[f];
      end
      check({tag, ":done_pulses"}, 32'(done_n), 32'(exp_good));
      check({tag, ":underrun_pulses"}, 32'(ur_n), 32'(exp_urun));
      check({tag, ":er_outside_frame"}, 32'(er_idle), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len1, gap, rdy_n, guard, len, u, tu;
      bit hold;

      repeat (3) @(negedge clk_125mhz);
      check("reset_outputs", 32'({gmii_txd, gmii_tx_en, gmii_tx_er, s_axis_tready,
                                  tx_busy, stat_frame_done, stat_underrun}), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk_125mhz);

      // 64-byte counting payload: no pad, 76 tx_en cycles.
      clear_all();
      cur.delete();
      for (int i = 0; i < 64; i++) cur.push_back(8'(i));
      model_frame(-1, -1);
      send(-1, -1, 1'b0);
      drain();
      analyze("p64");
      check("p64:en_cycles", 32'((g_ln.size() > 0) ? g_ln[0] : 0), 32'(76));
      check("p64:idle_busy", 32'(tx_busy), 32'(0));

      // Short frame padded to the minimum.
      clear_all(); rand_frame(14); model_frame(-1, -1); send(-1, -1, 1'b0); drain();
      analyze("p14");

      // Exactly minimum length: FCS directly after the last byte.
      clear_all(); rand_frame(60); model_frame(-1, -1); send(-1, -1, 1'b0); drain();
      analyze("p60");

      // Back-to-back frames with tvalid held high.
      clear_all();
      rand_frame($urandom_range(20, 80)); model_frame(-1, -1); send(-1, -1, 1'b1);
      rand_frame($urandom_range(1, 80));  model_frame(-1, -1); send(-1, -1, 1'b0);
      drain();
      analyze("b2b");
      if (g_st.size() >= 2) begin
         gap   = g_st[1] - (g_st[0] + g_ln[0]);
         rdy_n = 0;
         for (int i = g_st[0] + g_ln[0]; i <= g_st[1] + 6; i++) rdy_n += int'(s_rdy[i]);
         check("b2b:ifg_cycles", 32'(gap), 32'(IFG));
         check("b2b:ready_in_ifg_preamble", 32'(rdy_n), 32'(0));
      end

      // Underrun at beat 20 of a 40-byte frame, then a clean frame.
      clear_all();
      len1 = 40;
      rand_frame(len1); model_frame(20, -1); send(20, -1, 1'b1);
      rand_frame(30);   model_frame(-1, -1); send(-1, -1, 1'b0);
      drain();
      analyze("urun");
      if (g_st.size() >= 2) begin
         gap   = g_st[1] - (g_st[0] + g_ln[0]);
         rdy_n = 0;
         for (int i = g_st[0] + g_ln[0] - 1; i < g_st[1]; i++) rdy_n += int'(s_rdy[i]);
         check("urun:idle_cycles", 32'(gap), 32'((len1 - 20) + IFG));
         check("urun:dropped_beats", 32'(rdy_n), 32'(len1 - 20));
      end

      // tuser on byte 5 only.
      clear_all(); rand_frame(25); model_frame(-1, 5); send(-1, 5, 1'b0); drain();
      analyze("tuser");

      // Random mix of lengths, error marks, underruns and back-to-back starts.
      clear_all();
      for (int f = 0; f < 6; f++) begin
         len  = $urandom_range(1, 120);
         tu   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         u    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         hold = (f != 5) && ($urandom_range(0, 1) == 1);
         rand_frame(len);
         model_frame(u, tu);
         send(u, tu, hold);
      end
      drain();
      analyze("rnd");

      // Reset pulse in the middle of DATA, then a clean frame.
      rand_frame(40);
      guard = 0;
      for (int i = 0; i < 10; ) begin
         @(negedge clk_125mhz);
         s_axis_tdata  = cur[i];
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
         if (s_axis_tready) i++;
         guard++;
         if (guard > 500) begin
            check("rst_drv_timeout", 32'(i), 32'(10));
            break;
         end
      end
      @(negedge clk_125mhz);
      check("rst:en_before", 32'(gmii_tx_en), 32'(1));
      #1 rst_n = 1'b0;
      #1 check("rst:async_clear", 32'({gmii_tx_en, gmii_tx_er, s_axis_tready, tx_busy}), 32'(0));
      s_axis_tvalid = 1'b0;
      repeat (3) @(negedge clk_125mhz);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_125mhz);
      clear_all(); rand_frame(50); model_frame(-1, -1); send(-1, -1, 1'b0); drain();
      analyze("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
